// File: rtl/shad_priority_decoder.sv
// Purpose : expands an 8-bit priority code (0-15, or 0xF0 = none) into a 16-bit
//           one-hot/thermometer word, streamed out as two bytes, low byte first.
// Latency : code accepted on edge N -> low byte valid N+1, high byte N+2, ready N+3.
// Backpr. : byte_ready low stalls the current beat indefinitely; code_ready is low
//           whenever a word is in flight, so codes are held off upstream.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   code_in/code_valid/code_ready   code handshake (ready = idle and not in reset)
//   thermo               mode sampled with the code: 0 one-hot, 1 thermometer
//   byte_out/byte_valid/byte_ready/byte_last   two-beat output stream
//   err_cnt, err_clr     saturating count of rejected codes, and its clear
module shad_priority_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  input  logic       thermo,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       byte_last,
  output logic [7:0] err_cnt,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] word;
  logic [15:0] word_nxt;
  logic        accept;
  logic        legal;
  logic        is_none;
  logic [3:0]  pos;
  logic [7:0]  err_base;

  assign code_ready = (state == IDLE) && !rst;
  assign accept     = code_valid && code_ready;
  assign pos        = code_in[3:0];
  assign is_none    = (code_in == 8'hF0);
  assign legal      = (code_in[7:4] == 4'h0) || is_none;

  // Thermometer: shifting all-ones right by (15-n) leaves bits n..0 set.
  always_comb begin
    word_nxt = 16'h0000;
    if (!is_none) begin
      if (thermo) begin
        word_nxt = 16'hFFFF >> (4'd15 - pos);
      end else begin
        word_nxt = 16'h0001 << pos;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The word only changes on a legal accept, so a stalled beat stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= 16'h0000;
    end else if (accept && legal) begin
      word <= word_nxt;
    end
  end

  // Next-state logic; a rejected code leaves the FSM in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && legal) state_nxt = SEND_LO;
      SEND_LO: if (byte_ready)      state_nxt = SEND_HI;
      SEND_HI: if (byte_ready)      state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state/word only, so nothing from code_in leaks through.
  always_comb begin
    byte_valid = 1'b0;
    byte_out   = 8'h00;
    byte_last  = 1'b0;
    case (state)
      SEND_LO: begin
        byte_valid = 1'b1;
        byte_out   = word[7:0];
      end
      SEND_HI: begin
        byte_valid = 1'b1;
        byte_out   = word[15:8];
        byte_last  = 1'b1;
      end
      default: begin
        byte_valid = 1'b0;
      end
    endcase
  end

  // Clear takes effect first, then a same-cycle reject increments from zero.
  always_comb begin
    err_base = err_clr ? 8'h00 : err_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'h00;
    end else if (accept && !legal && (err_base != 8'hFF)) begin
      err_cnt <= err_base + 8'h01;
    end else begin
      err_cnt <= err_base;
    end
  end

endmodule

// File: tb/tb_shad_priority_decoder.sv
module tb_shad_priority_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic       thermo;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;
  logic [7:0] err_cnt;
  logic       err_clr;

  shad_priority_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .thermo     (thermo),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .err_cnt    (err_cnt),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] dat;
    bit         last;
    logic [7:0] code;
  } beat_t;

  beat_t exp_q[$];
  int    model_err = 0;
  logic [7:0] lo_byte = 8'h00;

  function automatic bit is_legal(input logic [7:0] c);
    return (c <= 8'h0F) || (c == 8'hF0);
  endfunction

  // Word from the arithmetic definition: 2^n, or 2^(n+1)-1.
  function automatic logic [15:0] expand(input logic [7:0] c, input bit th);
    int n;
    int w;
    n = int'(c) & 15;
    if (c == 8'hF0) return 16'h0000;
    w = th ? ((2 ** (n + 1)) - 1) : (2 ** n);
    return 16'(w);
  endfunction

  // Priority encoder model: index of highest set bit, 0xF0 if none.
  function automatic int enc(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      if (w[i]) return i;
    end
    return 'hF0;
  endfunction

  // Per-cycle monitor, sampled on the falling edge for the next rising edge.
  initial begin
    beat_t b;
    bit    idle;
    bit    rej;
    logic [15:0] w;
    forever begin
      @(negedge clk);
      check("err_cnt", int'(err_cnt), model_err);
      if (rst) begin
        check("code_ready_in_rst", int'(code_ready), 0);
        exp_q.delete();
        model_err = 0;
      end else begin
        idle = (exp_q.size() == 0);
        rej  = 1'b0;
        check("code_ready", int'(code_ready), int'(idle));
        check("byte_valid", int'(byte_valid), int'(!idle));
        if (byte_valid && !idle) begin
          check("byte_out", int'(byte_out), int'(exp_q[0].dat));
          check("byte_last", int'(byte_last), int'(exp_q[0].last));
          if (byte_ready) begin
            b = exp_q.pop_front();
            if (b.last) check("round_trip", enc({b.dat, lo_byte}), int'(b.code));
            else        lo_byte = b.dat;
          end
        end else if (!byte_valid) begin
          check("idle_byte_out", int'(byte_out), 0);
          check("idle_byte_last", int'(byte_last), 0);
        end
        if (code_valid && idle) begin
          if (is_legal(code_in)) begin
            w = expand(code_in, thermo);
            exp_q.push_back('{dat: w[7:0],  last: 1'b0, code: code_in});
            exp_q.push_back('{dat: w[15:8], last: 1'b1, code: code_in});
          end else begin
            rej = 1'b1;
          end
        end
        if (err_clr) model_err = 0;
        if (rej && model_err < 255) model_err++;
      end
    end
  end

  // ---------------- byte_ready driver ----------------
  bit rdy_rand  = 1'b0;
  bit rdy_force = 1'b1;

  initial begin
    byte_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      byte_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send(input logic [7:0] c, input logic th);
    bit ok;
    ok = 1'b0;
    code_in    = c;
    thermo     = th;
    code_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (code_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    code_valid = 1'b0;
    code_in    = 8'($urandom);
    thermo     = 1'($urandom);
    if (!ok) check("accept_timeout", int'(ok), 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (code_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) check("idle_timeout", int'(ok), 1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst        = 1'b1;
    code_in    = 8'h00;
    code_valid = 1'b0;
    thermo     = 1'b0;
    err_clr    = 1'b0;
    cycles(3);
    @(negedge clk);
    check("rst_byte_valid", int'(byte_valid), 0);
    check("rst_byte_out", int'(byte_out), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency example: accept on edge N, beats at N+1, N+2, ready at N+3.
    send(8'h05, 1'b0);
    @(negedge clk);
    check("lat_lo_valid", int'(byte_valid), 1);
    check("lat_lo_byte", int'(byte_out), 'h20);
    check("lat_lo_last", int'(byte_last), 0);
    @(negedge clk);
    check("lat_hi_byte", int'(byte_out), 'h00);
    check("lat_hi_last", int'(byte_last), 1);
    @(negedge clk);
    check("lat_ready_back", int'(code_ready), 1);
    @(posedge clk);
    #1;

    send(8'h0B, 1'b1);
    send(8'h0F, 1'b1);
    send(8'hF0, 1'b0);
    send(8'hF0, 1'b1);
    wait_idle();

    // Reject burst and saturation
    send(8'h10, 1'b0);
    send(8'hFF, 1'b1);
    send(8'hF1, 1'b0);
    @(negedge clk);
    check("err_cnt_3", int'(err_cnt), 3);
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) send(8'h20 + 8'(i % 200), 1'($urandom));
    @(negedge clk);
    check("err_cnt_sat", int'(err_cnt), 'hFF);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    send(8'hA5, 1'b0);
    err_clr = 1'b0;
    @(negedge clk);
    check("err_clr_plus_reject", int'(err_cnt), 1);
    @(posedge clk);
    #1;

    // Stall on the low byte
    rdy_force = 1'b0;
    send(8'h09, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_byte_out", int'(byte_out), 'h00);
      check("stall_byte_last", int'(byte_last), 0);
      check("stall_code_ready", int'(code_ready), 0);
    end
    @(posedge clk);
    #1;
    rdy_force = 1'b1;
    wait_idle();

    // Reset while the high byte is presented
    send(8'h03, 1'b1);
    @(posedge clk);
    #1;
    rdy_force = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("pre_rst_last", int'(byte_last), 1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    rdy_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_beat", int'(byte_valid), 0);
    end
    @(posedge clk);
    #1;

    // Sweep all positions in both modes, plus the "none" code
    for (int t = 0; t < 2; t++) begin
      for (int n = 0; n < 16; n++) send(8'(n), 1'(t));
      send(8'hF0, 1'(t));
    end
    wait_idle();

    // Randomized traffic with random backpressure and clears
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] c;
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5)      c = 8'($urandom_range(0, 15));
      else if (r == 6) c = 8'hF0;
      else             c = 8'($urandom);
      err_clr = ($urandom_range(0, 15) == 0);
      send(c, 1'($urandom));
      err_clr = 1'b0;
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
    end
    rdy_rand = 1'b0;
    wait_idle();
    cycles(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shad_priority_decoder.md
# shad_priority_decoder

Streaming priority decoder: the inverse of the team's 16-bit priority encoder. It accepts an 8-bit encoded position (0–15, or the encoder's "no bit set" code 0xF0) over a valid/ready handshake. It expands the position into a 16-bit one-hot or thermometer word and emits that word as two bytes, low byte first, over a second valid/ready handshake. It sits downstream of the encoder on the shad_adder tile and gives round-trip test and mask generation.

## Interface
Parameters:
- None. Widths are fixed: 8-bit code in, 16-bit word out as two bytes.

Ports:
- clk  in  1  sole clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- code_in  in  8  encoded position
- code_valid  in  1  code_in is valid
- code_ready  out  1  block can accept a code this cycle
- thermo  in  1  mode, sampled with the code: 0 = one-hot, 1 = thermometer
- byte_out  out  8  output byte
- byte_valid  out  1  byte_out is valid
- byte_ready  in  1  downstream accepts byte_out this cycle
- byte_last  out  1  high while the high byte (second beat) is presented
- err_cnt  out  8  saturating count of rejected codes
- err_clr  in  1  clears err_cnt

## Operation
- FSM states and meaning:
  - IDLE: waiting for a code.
  - SEND_LO: presenting word[7:0].
  - SEND_HI: presenting word[15:8].
- code_ready = (state == IDLE) && !rst. Combinational from state only; no dependence on code_valid.
- A code is accepted when code_valid && code_ready. On accept:
  - code_in 0x00–0x0F, n = code_in[3:0]:
    - thermo = 0: word = 1 << n.
    - thermo = 1: word = (2 << n) − 1, i.e. bits n..0 set. n = 15 gives 0xFFFF.
    - Next state SEND_LO.
  - code_in 0xF0: word = 0x0000 in both modes. Next state SEND_LO.
  - Any other value: rejected. No output beats, state stays IDLE, err_cnt += 1, saturating at 0xFF.
- SEND_LO: byte_valid = 1, byte_out = word[7:0], byte_last = 0. When byte_ready, next state SEND_HI.
- SEND_HI: byte_valid = 1, byte_out = word[15:8], byte_last = 1. When byte_ready, next state IDLE.
- byte_out and byte_last stay stable while byte_valid && !byte_ready. The word register is not modified outside an accept.
- While byte_valid = 0, byte_out = 0x00 and byte_last = 0.
- Every byte emitted is registered; there is no combinational path from code_in to byte_out.
- err_clr:
  - err_clr alone: err_cnt = 0 next cycle.
  - err_clr in the same cycle as a rejected accept: err_cnt = 1 next cycle (clear, then increment).
  - err_clr does not affect the FSM.
- Round-trip property: feeding {byte_hi, byte_lo} into the priority encoder returns code_in, in both modes, including 0xF0.

## Timing
- Reset values, applied on the first rising edge with rst = 1: state IDLE, byte_valid 0, byte_out 0x00, byte_last 0, err_cnt 0x00, word 0x0000. code_ready reads 0 while rst = 1.
- Reset mid-operation: any in-flight word is discarded. Outputs return to reset values on that edge, and no further beat of that word is emitted.
- Latency: code accepted on edge N gives low byte valid in cycle N+1. With byte_ready held at 1, the high byte is valid in N+2 and code_ready returns high in N+3.
- Throughput: one code per 3 cycles at best. Downstream stalls extend SEND_LO and SEND_HI without limit.
- A rejected code takes 1 cycle; code_ready stays high, so back-to-back rejects count every cycle.
- code_valid may be asserted while code_ready = 0. The code is held off with no side effects.

## Test plan
- Reset, then code 0x05 with thermo = 0 and byte_ready = 1: low byte 0x20 at N+1 (byte_last 0), high byte 0x00 at N+2 (byte_last 1), code_ready high at N+3.
- Code 0x0B with thermo = 1: beats 0xFF then 0x0F. Code 0x0F with thermo = 1: beats 0xFF then 0xFF.
- Code 0xF0 in both modes: beats 0x00 then 0x00, with no err_cnt change.
- Codes 0x10, 0xFF, 0xF1 back-to-back: no beats, err_cnt = 3. Then 300 rejects: err_cnt = 0xFF. Then err_clr together with a reject: err_cnt = 1.
- Code 0x09 with byte_ready = 0 for 5 cycles: byte_out stays 0x00 (low byte), byte_last 0, and code_ready stays 0 throughout. Release: 0x00 then 0x02. Then assert rst during SEND_HI of the next word: byte_valid 0 on the next edge and no further beat.
- All 16 positions × both modes plus 0xF0, each output fed to the priority encoder model: recovered value equals code_in.
